// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types for the unified memory port arbiter: address/data word types,
// the arbiter ownership state and a small decode helper.
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    // Port ownership: per-cycle arbitration, or held by a locked external burst.
    typedef enum logic [0:0] {
        ARB__FREE     = 1'b0,
        ARB__EXT_LOCK = 1'b1
    } arb_state_t;

    // A granted access that is not a write returns read data one cycle later.
    function automatic logic is_read(input logic gnt, input logic we);
        return gnt & ~we;
    endfunction

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the two requester channels (core, external) and the memory port.
//   master : requester/memory side (drives requests and mem_rd, sees grants)
//   slave  : arbiter side (mem_arbiter)
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    // core requester
    logic  core_req;
    logic  core_we;
    addr_t core_addr;
    data_t core_wdata;
    logic  core_gnt;
    logic  core_rvalid;
    data_t core_rdata;
    logic  core_stall;

    // external requester (loader / debug DMA)
    logic  ext_req;
    logic  ext_we;
    addr_t ext_addr;
    data_t ext_wdata;
    logic  ext_lock;
    logic  ext_gnt;
    logic  ext_rvalid;
    data_t ext_rdata;

    // memory port
    addr_t mem_a;
    data_t mem_wd;
    logic  mem_we;
    data_t mem_rd;

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata, core_stall,
        output ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_a, mem_wd, mem_we,
        output mem_rd
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata, core_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_a, mem_wd, mem_we,
        input  mem_rd
    );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter_wait_counter.sv
// arb_wait_counter
// Saturating count of consecutive cycles the external requester was denied.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : external request pending and not granted this cycle
//   clr        : external granted, or no external request
//   sat        : count has reached STARVE_LIMIT
module arb_wait_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_r;

    // Denied-cycle counter: clear wins over increment, holds at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != LIMIT_C)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign sat = (cnt_r == LIMIT_C);

endmodule : arb_wait_counter

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single instruction/data memory port between the multicycle core
// and an external requester. Core has priority, but an external request that
// has been denied STARVE_LIMIT consecutive cycles wins over the core. A
// granted external access with ext_lock set keeps the port until ext_lock
// drops. Grants are combinational; read data returns registered one cycle
// after the grant with a one-cycle rvalid pulse.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : mem_arbiter_if.slave -- core/ext request channels, memory port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    arb_state_t state_r;

    logic  core_gnt_s;
    logic  ext_gnt_s;
    logic  sat_s;
    logic  wait_inc_s;
    logic  wait_clr_s;
    logic  mem_we_s;
    logic  core_stall_s;
    addr_t mem_a_s;
    data_t mem_wd_s;

    logic  core_rvalid_r;
    data_t core_rdata_r;
    logic  ext_rvalid_r;
    data_t ext_rdata_r;

    // Grant decision for the current cycle; nothing is granted during reset.
    always_comb begin
        core_gnt_s = 1'b0;
        ext_gnt_s  = 1'b0;
        if (reset) begin
            core_gnt_s = 1'b0;
            ext_gnt_s  = 1'b0;
        end else begin
            case (state_r)
                ARB__FREE: begin
                    // A starved external request overrides core priority.
                    if (bus.ext_req && (!bus.core_req || sat_s)) begin
                        ext_gnt_s = 1'b1;
                    end else if (bus.core_req) begin
                        core_gnt_s = 1'b1;
                    end else begin
                        core_gnt_s = 1'b0;
                        ext_gnt_s  = 1'b0;
                    end
                end
                ARB__EXT_LOCK: begin
                    ext_gnt_s  = bus.ext_req;
                    core_gnt_s = 1'b0;
                end
                default: begin
                    core_gnt_s = 1'b0;
                    ext_gnt_s  = 1'b0;
                end
            endcase
        end
    end

    // Memory port drive: follow the external requester only when it is granted.
    always_comb begin
        mem_a_s      = bus.core_addr;
        mem_wd_s     = bus.core_wdata;
        if (ext_gnt_s) begin
            mem_a_s  = bus.ext_addr;
            mem_wd_s = bus.ext_wdata;
        end else begin
            mem_a_s  = bus.core_addr;
            mem_wd_s = bus.core_wdata;
        end
        mem_we_s     = (core_gnt_s & bus.core_we) | (ext_gnt_s & bus.ext_we);
        core_stall_s = bus.core_req & ~core_gnt_s & ~reset;
    end

    assign wait_inc_s = bus.ext_req & ~ext_gnt_s;
    assign wait_clr_s = ext_gnt_s | ~bus.ext_req;

    arb_wait_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_wait_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (wait_inc_s),
        .clr   (wait_clr_s),
        .sat   (sat_s)
    );

    // Ownership FSM: a locked external grant takes the port until lock drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ARB__FREE;
        end else begin
            case (state_r)
                ARB__FREE: begin
                    if (ext_gnt_s && bus.ext_lock) begin
                        state_r <= ARB__EXT_LOCK;
                    end else begin
                        state_r <= ARB__FREE;
                    end
                end
                ARB__EXT_LOCK: begin
                    if (!bus.ext_lock) begin
                        state_r <= ARB__FREE;
                    end else begin
                        state_r <= ARB__EXT_LOCK;
                    end
                end
                default: begin
                    state_r <= ARB__FREE;
                end
            endcase
        end
    end

    // Core read return: capture on a granted read, pulse rvalid for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_rvalid_r <= 1'b0;
            core_rdata_r  <= '0;
        end else begin
            core_rvalid_r <= is_read(core_gnt_s, bus.core_we);
            if (is_read(core_gnt_s, bus.core_we)) begin
                core_rdata_r <= bus.mem_rd;
            end else begin
                core_rdata_r <= core_rdata_r;
            end
        end
    end

    // External read return: same policy as the core channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_rvalid_r <= 1'b0;
            ext_rdata_r  <= '0;
        end else begin
            ext_rvalid_r <= is_read(ext_gnt_s, bus.ext_we);
            if (is_read(ext_gnt_s, bus.ext_we)) begin
                ext_rdata_r <= bus.mem_rd;
            end else begin
                ext_rdata_r <= ext_rdata_r;
            end
        end
    end

    assign bus.core_gnt    = core_gnt_s;
    assign bus.core_stall  = core_stall_s;
    assign bus.core_rvalid = core_rvalid_r;
    assign bus.core_rdata  = core_rdata_r;
    assign bus.ext_gnt     = ext_gnt_s;
    assign bus.ext_rvalid  = ext_rvalid_r;
    assign bus.ext_rdata   = ext_rdata_r;
    assign bus.mem_a       = mem_a_s;
    assign bus.mem_wd      = mem_wd_s;
    assign bus.mem_we      = mem_we_s;

endmodule : mem_arbiter
